// File: rtl/fm_logsin_exp.sv
// FM operator output stage: phase + log attenuation to signed sample.
// Quarter-wave log-sine, log add, exp table with shift, sign restore.
module fm_logsin_exp #(
  parameter int PSZ = 10,
  parameter int LSZ = 12,
  parameter int ESZ = 8,
  parameter int OSZ = 12,
  parameter int TSZ = 3
) (
  input  logic           clk,
  input  logic           reset_n,
  input  logic           in_valid,
  input  logic [TSZ-1:0] in_tag,
  input  logic [PSZ-1:0] phase,
  input  logic [LSZ-1:0] atten,
  output logic           out_valid,
  output logic [TSZ-1:0] out_tag,
  output logic [OSZ-1:0] out_sample
);

  localparam int AW = PSZ - 2;
  localparam int N  = 2 ** AW;
  localparam int EN = 2 ** ESZ;
  localparam int EW = 10;
  localparam int IW = LSZ + 1 - ESZ;
  localparam int MW = EW + 1;
  localparam logic [IW-1:0] IMAX = IW'(OSZ - 1);
  localparam real PI = 3.141592653589793;

  // Tables are computed at elaboration from the
  // same formulas used to build the offline images.
  function automatic logic [LSZ-1:0] logsin_val(int i);
    real x;
    x = (real'(i) + 0.5) * PI / real'(2 * N);
    return LSZ'($rtoi(-$ln($sin(x)) / $ln(2.0)
                      * 256.0 + 0.5));
  endfunction

  function automatic logic [EW-1:0] exp_val(int j);
    real x;
    x = $pow(2.0, real'(j) / real'(EN)) - 1.0;
    return EW'($rtoi(x * 1024.0 + 0.5));
  endfunction

  logic [LSZ-1:0] ls_rom [N];
  logic [EW-1:0]  ex_rom [EN];

  for (genvar gi = 0; gi < N; gi++) begin : g_ls
    assign ls_rom[gi] = logsin_val(gi);
  end

  for (genvar gj = 0; gj < EN; gj++) begin : g_ex
    assign ex_rom[gj] = exp_val(gj);
  end

  // input capture
  logic           v0_q;
  logic [TSZ-1:0] t0_q;
  logic [PSZ-1:0] ph0_q;
  logic [LSZ-1:0] at0_q;
  // S1: folded address
  logic           v1_q, s1_q;
  logic [TSZ-1:0] t1_q;
  logic [AW-1:0]  a1_q;
  logic [LSZ-1:0] at1_q;
  // S2: log-sine read
  logic           v2_q, s2_q;
  logic [TSZ-1:0] t2_q;
  logic [LSZ-1:0] ls2_q;
  logic [LSZ-1:0] at2_q;
  // S3: exp read
  logic           v3_q, s3_q;
  logic [TSZ-1:0] t3_q;
  logic [IW-1:0]  i3_q;
  logic [EW-1:0]  ex3_q;
  // S4: output
  logic           v4_q;
  logic [TSZ-1:0] t4_q;
  logic [OSZ-1:0] smp_q, smp_d;

  logic           sign0;
  logic [AW-1:0]  addr0;
  logic [LSZ:0]   sum2;
  logic [ESZ-1:0] frac2;
  logic [MW-1:0]  mag3;

  // Quarter-wave fold: top bit is sign, next bit mirrors.
  always_comb begin
    sign0 = ph0_q[PSZ-1];
    addr0 = ph0_q[AW-1:0] ^ {AW{ph0_q[PSZ-2]}};
  end

  // Log-domain add; exp table stores the inverted fraction.
  always_comb begin
    sum2  = {1'b0, ls2_q} + {1'b0, at2_q};
    frac2 = ~sum2[ESZ-1:0];
  end

  // Mantissa shift, underflow to zero, sign restore.
  always_comb begin
    mag3 = '0;
    if (i3_q < IMAX) begin
      mag3 = {1'b1, ex3_q} >> i3_q;
    end
    smp_d = s3_q ? -{1'b0, mag3} : {1'b0, mag3};
  end

  // Control path: valid, sign and tag are cleared by reset.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      v0_q <= 1'b0;
      t0_q <= '0;
      v1_q <= 1'b0;
      s1_q <= 1'b0;
      t1_q <= '0;
      v2_q <= 1'b0;
      s2_q <= 1'b0;
      t2_q <= '0;
      v3_q <= 1'b0;
      s3_q <= 1'b0;
      t3_q <= '0;
      v4_q <= 1'b0;
      t4_q <= '0;
      smp_q <= '0;
    end else begin
      v0_q <= in_valid;
      t0_q <= in_tag;
      v1_q <= v0_q;
      s1_q <= sign0;
      t1_q <= t0_q;
      v2_q <= v1_q;
      s2_q <= s1_q;
      t2_q <= t1_q;
      v3_q <= v2_q;
      s3_q <= s2_q;
      t3_q <= t2_q;
      v4_q <= v3_q;
      if (v3_q) begin
        t4_q  <= t3_q;
        smp_q <= smp_d;
      end
    end
  end

  // Data path: ROM reads and operands, never reset.
  always_ff @(posedge clk) begin
    ph0_q <= phase;
    at0_q <= atten;
    a1_q  <= addr0;
    at1_q <= at0_q;
    ls2_q <= ls_rom[a1_q];
    at2_q <= at1_q;
    i3_q  <= sum2[LSZ:ESZ];
    ex3_q <= ex_rom[frac2];
  end

  assign out_valid  = v4_q;
  assign out_tag    = t4_q;
  assign out_sample = smp_q;

endmodule
